tnkiii_linebuf_ctrl: RTL and testbench

- Sequencer for the ping-pong sprite line buffer.
- Derives the four per-pixel phase enables (CK0, CK0n, CK1, CK1n) from one master clock enable.
- Toggles the write/read bank once per line, loads the read counter at a programmable horizontal position, and takes sprite-strip write requests from the sprite engine. Each accepted request becomes a write-address load plus a counted burst of pixel writes.
- Sits between the sprite fetch engine and the line buffer datapath. Its outputs drive LT, CK0/CK1, LD/FCK, FL_Y, HLD, FY/FY8 and INVn directly.

---
 rtl/tnkiii_linebuf_pkg.sv | 43 ++++
 rtl/tnkiii_pix_phase_gen.sv | 57 +++++
 rtl/tnkiii_linebuf_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_tnkiii_linebuf_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tnkiii_linebuf_pkg.sv
// Shared types, default horizontal positions and small helpers for the
// sprite line buffer sequencer.
package tnkiii_linebuf_pkg;

    // Position inside one pixel period; one value per phase enable.
    typedef enum logic [1:0] {
        PH_CK0  = 2'd0,
        PH_CK0N = 2'd1,
        PH_CK1  = 2'd2,
        PH_CK1N = 2'd3
    } phase_e;

    // Sprite strip write sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } fsm_e;

    localparam logic [8:0] LINE_END_H_DEF = 9'd383;
    localparam logic [8:0] RD_LOAD_H_DEF  = 9'd380;
    localparam logic [8:0] WR_GUARD_H_DEF = 9'd376;
    localparam logic [4:0] MAX_LEN_DEF    = 5'd16;

    // Phase sequence CK0 -> CK0n -> CK1 -> CK1n -> CK0.
    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_CK0:  nxt = PH_CK0N;
            PH_CK0N: nxt = PH_CK1;
            PH_CK1:  nxt = PH_CK1N;
            PH_CK1N: nxt = PH_CK0;
            default: nxt = PH_CK0;
        endcase
        return nxt;
    endfunction

    // A strip length is usable when it is 1..max_len pixels.
    function automatic logic len_valid(input logic [4:0] len, input logic [4:0] max_len);
        return (len != 5'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/tnkiii_pix_phase_gen.sv
// Splits the 4x pixel-rate master enable into the four one-clk phase
// enables. The *_stb outputs are the same decisions one clk early so the
// parent can register events that line up exactly with CK0 / CK1.
module tnkiii_pix_phase_gen
    import tnkiii_linebuf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pix_cen,
    output logic ck0_stb,
    output logic ck1_stb,
    output logic ck0,
    output logic ck0n,
    output logic ck1,
    output logic ck1n
);

    phase_e ph_r;
    logic   ck0_r;
    logic   ck0n_r;
    logic   ck1_r;
    logic   ck1n_r;
    logic   ck0n_stb_s;
    logic   ck1n_stb_s;

    assign ck0_stb    = pix_cen && (ph_r == PH_CK0);
    assign ck0n_stb_s = pix_cen && (ph_r == PH_CK0N);
    assign ck1_stb    = pix_cen && (ph_r == PH_CK1);
    assign ck1n_stb_s = pix_cen && (ph_r == PH_CK1N);

    // Phase counter and registered phase enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_r   <= PH_CK0;
            ck0_r  <= 1'b0;
            ck0n_r <= 1'b0;
            ck1_r  <= 1'b0;
            ck1n_r <= 1'b0;
        end else begin
            ck0_r  <= ck0_stb;
            ck0n_r <= ck0n_stb_s;
            ck1_r  <= ck1_stb;
            ck1n_r <= ck1n_stb_s;
            if (pix_cen) begin
                ph_r <= next_phase(ph_r);
            end else begin
                ph_r <= ph_r;
            end
        end
    end

    assign ck0  = ck0_r;
    assign ck0n = ck0n_r;
    assign ck1  = ck1_r;
    assign ck1n = ck1n_r;

endmodule

// File: rtl/tnkiii_linebuf_ctrl.sv
// Ping-pong sprite line buffer sequencer: phase enables, per-line bank
// swap and read-counter preload, and the sprite strip write sequencer.
module tnkiii_linebuf_ctrl
    import tnkiii_linebuf_pkg::*;
#(
    parameter logic [8:0] LINE_END_H = LINE_END_H_DEF,
    parameter logic [8:0] RD_LOAD_H  = RD_LOAD_H_DEF,
    parameter logic [8:0] WR_GUARD_H = WR_GUARD_H_DEF,
    parameter logic [4:0] MAX_LEN    = MAX_LEN_DEF
) (
    input  logic       clk,
    input  logic       VIDEO_RSTn,
    input  logic       PIX_CEN,
    input  logic [8:0] H_CNT,
    input  logic       FLIP,
    input  logic [8:0] RD_BASE,
    input  logic       SPR_REQ,
    input  logic [8:0] SPR_X,
    input  logic [4:0] SPR_LEN,
    output logic       SPR_ACK,
    output logic       SPR_PIX,
    output logic       CK0,
    output logic       CK0n,
    output logic       CK1,
    output logic       CK1n,
    output logic       LT,
    output logic       BANK,
    output logic       LD,
    output logic       FCK,
    output logic [8:0] FL_Y,
    output logic       HLD,
    output logic       FY8,
    output logic [7:0] FY,
    output logic       INVn,
    output logic       OVERRUN
);

    logic       ck0_stb_s;
    logic       ck1_stb_s;
    logic       line_end_s;
    logic       rd_load_s;
    logic       busy_s;

    logic       lt_r;
    logic       bank_r;
    logic       hld_r;
    logic       inv_n_r;
    logic [8:0] fy_r;

    fsm_e       state_r;
    logic [4:0] cnt_r;
    logic [8:0] fl_y_r;
    logic       ld_r;
    logic       fck_r;
    logic       spr_pix_r;
    logic       spr_ack_r;
    logic       ack_due_r;
    logic       overrun_r;

    tnkiii_pix_phase_gen u_phase (
        .clk     (clk),
        .rst_n   (VIDEO_RSTn),
        .pix_cen (PIX_CEN),
        .ck0_stb (ck0_stb_s),
        .ck1_stb (ck1_stb_s),
        .ck0     (CK0),
        .ck0n    (CK0n),
        .ck1     (CK1),
        .ck1n    (CK1n)
    );

    // H_CNT is only looked at on the CK1 phase for line events.
    assign line_end_s = ck1_stb_s && (H_CNT == LINE_END_H);
    assign rd_load_s  = ck1_stb_s && (H_CNT == RD_LOAD_H);
    assign busy_s     = (state_r == LOAD) || (state_r == WRITE);

    // Line toggle, bank swap, readout latches and the read-load strobe.
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            lt_r    <= 1'b0;
            bank_r  <= 1'b0;
            hld_r   <= 1'b1;
            inv_n_r <= 1'b1;
            fy_r    <= 9'd0;
        end else begin
            lt_r <= line_end_s;
            if (line_end_s) begin
                bank_r  <= ~bank_r;
                inv_n_r <= ~FLIP;
                fy_r    <= RD_BASE;
            end else begin
                bank_r  <= bank_r;
                inv_n_r <= inv_n_r;
                fy_r    <= fy_r;
            end
            // HLD spans exactly one CK1-to-CK1 period.
            if (ck1_stb_s) begin
                hld_r <= ~rd_load_s;
            end else begin
                hld_r <= hld_r;
            end
        end
    end

    // Strip write sequencer: accept, address load, counted pixel burst,
    // and truncation when the line ends under a burst.
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            fl_y_r    <= 9'd0;
            ld_r      <= 1'b0;
            fck_r     <= 1'b0;
            spr_pix_r <= 1'b0;
            spr_ack_r <= 1'b0;
            ack_due_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            spr_pix_r <= 1'b0;
            spr_ack_r <= ack_due_r;
            ack_due_r <= 1'b0;
            fck_r     <= 1'b0;
            if (line_end_s) begin
                // Set wins over the per-line clear when a burst is cut.
                overrun_r <= busy_s;
                if (busy_s) begin
                    spr_ack_r <= 1'b1;
                    state_r   <= IDLE;
                    ld_r      <= 1'b0;
                end else begin
                    state_r   <= state_r;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (ck0_stb_s && SPR_REQ) begin
                            if (!len_valid(SPR_LEN, MAX_LEN)) begin
                                spr_ack_r <= 1'b1;
                            end else if (H_CNT < WR_GUARD_H) begin
                                fl_y_r  <= SPR_X;
                                cnt_r   <= SPR_LEN;
                                ld_r    <= 1'b1;
                                fck_r   <= 1'b1;
                                state_r <= LOAD;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD: begin
                        // The CK0 that ends the load is also the first pixel.
                        if (ck0_stb_s) begin
                            ld_r      <= 1'b0;
                            spr_pix_r <= 1'b1;
                            cnt_r     <= cnt_r - 5'd1;
                            state_r   <= WRITE;
                        end else begin
                            state_r   <= LOAD;
                        end
                    end
                    WRITE: begin
                        if (ck0_stb_s) begin
                            if (cnt_r == 5'd0) begin
                                ack_due_r <= 1'b1;
                                state_r   <= IDLE;
                            end else begin
                                spr_pix_r <= 1'b1;
                                cnt_r     <= cnt_r - 5'd1;
                            end
                        end else begin
                            state_r <= WRITE;
                        end
                    end
                    default: begin
                        ld_r    <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign LT      = lt_r;
    assign BANK    = bank_r;
    assign HLD     = hld_r;
    assign INVn    = inv_n_r;
    assign FY8     = fy_r[8];
    assign FY      = fy_r[7:0];
    assign LD      = ld_r;
    assign FCK     = fck_r;
    assign FL_Y    = fl_y_r;
    assign SPR_PIX = spr_pix_r;
    assign SPR_ACK = spr_ack_r;
    assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_tnkiii_linebuf_ctrl.sv
// Directed bench for the sprite line buffer sequencer. A small reference
// model tracks phase, line and readout state; strip requests push their
// expected outcome to a queue that is checked when SPR_ACK appears.
module tb_tnkiii_linebuf_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_cen;
    logic [8:0] h_cnt;
    logic       flip;
    logic [8:0] rd_base;
    logic       spr_req;
    logic [8:0] spr_x;
    logic [4:0] spr_len;

    logic       SPR_ACK, SPR_PIX, CK0, CK0n, CK1, CK1n, LT, BANK, LD, FCK;
    logic [8:0] FL_Y;
    logic       HLD, FY8, INVn, OVERRUN;
    logic [7:0] FY;

    always #5 clk = ~clk;

    tnkiii_linebuf_ctrl dut (
        .clk(clk), .VIDEO_RSTn(rst_n), .PIX_CEN(pix_cen), .H_CNT(h_cnt),
        .FLIP(flip), .RD_BASE(rd_base), .SPR_REQ(spr_req), .SPR_X(spr_x),
        .SPR_LEN(spr_len), .SPR_ACK(SPR_ACK), .SPR_PIX(SPR_PIX),
        .CK0(CK0), .CK0n(CK0n), .CK1(CK1), .CK1n(CK1n), .LT(LT), .BANK(BANK),
        .LD(LD), .FCK(FCK), .FL_Y(FL_Y), .HLD(HLD), .FY8(FY8), .FY(FY),
        .INVn(INVn), .OVERRUN(OVERRUN)
    );

    typedef struct {
        int         pix;
        int         ld;
        int         fck;
        logic       ovr;
        logic [8:0] fly;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    int vectors = 0;
    int errors  = 0;
    int pix_c, ld_c, fck_c, lat_c, hld_low_c, ack_total;

    // Reference model state
    int         m_ph;
    logic       m_bank, m_hld, m_inv;
    logic [8:0] m_fy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_bank = 1'b0; m_hld = 1'b1; m_inv = 1'b1; m_fy = 9'd0;
        hld_low_c = 0;
    endtask

    // One clk: capture inputs at the edge, sample outputs 1 time unit later.
    task automatic tick();
        logic       c, r, f;
        logic [8:0] h, rb;
        logic [3:0] ckexp;
        logic       ltexp;
        exp_t       e;
        c = pix_cen; r = rst_n; h = h_cnt; rb = rd_base; f = flip;
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
            ckexp = 4'b0000;
            ltexp = 1'b0;
        end else begin
            ckexp = c ? (4'b1000 >> m_ph) : 4'b0000;
            ltexp = c && (m_ph == 2) && (h == 9'd383);
            if (c && (m_ph == 2)) begin
                m_hld = (h != 9'd380);
                if (h == 9'd383) begin
                    m_bank = ~m_bank;
                    m_inv  = ~f;
                    m_fy   = rb;
                end
            end
            if (c) m_ph = (m_ph + 1) % 4;
        end
        chk("line_vec", {CK0, CK0n, CK1, CK1n, LT, BANK, HLD, INVn, FY8, FY},
            {ckexp, ltexp, m_bank, m_hld, m_inv, m_fy});
        if (r && !HLD) hld_low_c++;
        if (LT) begin
            chk("hld_low_clks", hld_low_c, 4);
            hld_low_c = 0;
        end
        lat_c++;
        if (SPR_PIX) pix_c++;
        if (LD)      ld_c++;
        if (FCK)     fck_c++;
        if (SPR_ACK) begin
            ack_total++;
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", SPR_ACK, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("strip_pix", pix_c, e.pix);
                chk("strip_ld_clks", ld_c, e.ld);
                chk("strip_fck", fck_c, e.fck);
                chk("strip_overrun", OVERRUN, e.ovr);
                chk("strip_fl_y", FL_Y, e.fly);
                chk("strip_ack_latency", lat_c, e.lat);
            end
            spr_req = 1'b0;
        end
    endtask

    task automatic run_h(input int lo, input int hi);
        for (int h = lo; h <= hi; h++) begin
            h_cnt = h[8:0];
            repeat (4) tick();
        end
    endtask

    task automatic req(input logic [8:0] x, input logic [4:0] len, input int epix,
                       input int eld, input int efck, input logic eovr,
                       input logic [8:0] efly, input int elat, input bit push);
        exp_t e;
        spr_x = x; spr_len = len; spr_req = 1'b1;
        pix_c = 0; ld_c = 0; fck_c = 0; lat_c = -1;
        if (push) begin
            e.pix = epix; e.ld = eld; e.fck = efck; e.ovr = eovr; e.fly = efly; e.lat = elat;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        int acks_before;
        rst_n = 1'b0; pix_cen = 1'b0; h_cnt = 9'd0; flip = 1'b0; rd_base = 9'd0;
        spr_req = 1'b0; spr_x = 9'd0; spr_len = 5'd0;
        pix_c = 0; ld_c = 0; fck_c = 0; lat_c = 0; ack_total = 0;
        model_reset();

        // Reset state
        tick(); tick();
        chk("reset_strip_outs", {LD, FCK, SPR_ACK, SPR_PIX, OVERRUN, FL_Y}, 14'd0);
        rst_n = 1'b1;

        // Free-running phases, then gapped enables
        pix_cen = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            pix_cen = (i % 2 == 0);
            tick();
        end
        pix_cen = 1'b1;

        // Line 1: normal strip, invalid lengths, line-end latches
        rd_base = 9'h1F0; flip = 1'b1;
        run_h(0, 9);
        req(9'd100, 5'd4, 4, 4, 1, 1'b0, 9'd100, 21, 1'b1);
        run_h(10, 19);
        req(9'd7, 5'd0, 0, 0, 0, 1'b0, 9'd100, 0, 1'b1);
        run_h(20, 29);
        req(9'd8, 5'd17, 0, 0, 0, 1'b0, 9'd100, 0, 1'b1);
        run_h(30, 383);
        chk("l1_bank", BANK, 1'b1);
        chk("l1_fy", {FY8, FY}, 9'h1F0);
        chk("l1_invn", INVn, 1'b0);
        chk("l1_acks", ack_total, 3);

        // Line 2: long strip truncated by line end
        rd_base = 9'h0AB; flip = 1'b0;
        run_h(0, 369);
        req(9'd200, 5'd16, 13, 4, 1, 1'b1, 9'd200, 54, 1'b1);
        run_h(370, 383);
        chk("l2_overrun", OVERRUN, 1'b1);
        chk("l2_bank", BANK, 1'b0);
        chk("l2_fy", {FY8, FY}, 9'h0AB);

        // Line 3: overrun persists, clears at LT; guarded request waits
        run_h(0, 199);
        chk("l3_overrun_held", OVERRUN, 1'b1);
        run_h(200, 376);
        acks_before = ack_total;
        req(9'd60, 5'd5, 5, 4, 1, 1'b0, 9'd60, 53, 1'b1);
        run_h(377, 383);
        chk("l3_overrun_clr", OVERRUN, 1'b0);
        chk("guard_no_ld", ld_c, 0);
        chk("guard_no_ack", ack_total, acks_before);

        // Line 4: guarded request completes, then async reset mid-burst
        run_h(0, 9);
        chk("guard_done_acks", ack_total, acks_before + 1);
        req(9'd50, 5'd8, 0, 0, 0, 1'b0, 9'd0, 0, 1'b0);
        run_h(10, 13);
        h_cnt = 9'd14;
        tick();
        chk("pre_rst_pix", pix_c, 4);
        chk("pre_rst_fly", FL_Y, 9'd50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs",
            {CK0, CK0n, CK1, CK1n, LT, BANK, LD, FCK, SPR_ACK, SPR_PIX, FL_Y, FY8, FY, OVERRUN, HLD, INVn},
            {4'b0000, 6'b000000, 9'd0, 9'd0, 3'b011});
        spr_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        pix_c = 0; ld_c = 0;
        run_h(0, 9);
        chk("post_rst_pix", pix_c, 0);
        chk("post_rst_ld", ld_c, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
